nv_nvdla_mcif_write_cq: RTL

Write-path context queue of the MCIF. For every AXI AW burst issued, ingress pushes a 3-bit context record, {len[1:0], require_ack}, tagged with the issuing DMA thread. Five independent in-order FIFOs hold the records, one per thread. Write egress pops the head record of a thread when that thread's AXI B response arrives, and uses it to generate the completion pulse and the outstanding-count return.

---
 rtl/nv_nvdla_mcif_write_cq_pkg.sv | 32 +++
 rtl/nv_nvdla_mcif_write_cq_if.sv | 40 ++++
 rtl/nv_nvdla_mcif_write_cq_fifo.sv | 54 +++++
 rtl/nv_nvdla_mcif_write_cq.sv | 90 +++++++++
 4 files changed

// File: rtl/nv_nvdla_mcif_write_cq_pkg.sv
// Shared types and constants for the MCIF write context queue.
//   CQ_PD_W / CQ_THREADS : record width and number of per-thread FIFOs
//   CQ_TID_*             : DMA thread ids carried on cq_wr_thread_id
//   REQ_ACK_BIT/LEN_LSB  : bit offsets of the record fields
package nv_nvdla_mcif_write_cq_pkg;

    localparam int unsigned CQ_PD_W    = 3;
    localparam int unsigned CQ_THREADS = 5;
    localparam int unsigned CQ_TID_W   = 3;
    localparam int unsigned CQ_LEN_W   = 2;

    localparam logic [CQ_TID_W-1:0] CQ_TID_BDMA = 3'd0;
    localparam logic [CQ_TID_W-1:0] CQ_TID_SDP  = 3'd1;
    localparam logic [CQ_TID_W-1:0] CQ_TID_PDP  = 3'd2;
    localparam logic [CQ_TID_W-1:0] CQ_TID_CDP  = 3'd3;
    localparam logic [CQ_TID_W-1:0] CQ_TID_RBK  = 3'd4;

    localparam int unsigned REQ_ACK_BIT = 0;
    localparam int unsigned LEN_LSB     = 1;

    // Context record pushed per AW burst: {len, require_ack}
    typedef struct packed {
        logic [CQ_LEN_W-1:0] len;
        logic                require_ack;
    } cq_rec_t;

    // Thread ids above RBK do not map to a FIFO
    function automatic logic cq_tid_valid(input logic [CQ_TID_W-1:0] tid);
        return tid <= CQ_TID_RBK;
    endfunction

endpackage

// File: rtl/nv_nvdla_mcif_write_cq_if.sv
// Handshake bundle between ingress/egress and the write context queue.
//   cq_wr_*   : single push port (ingress -> queue)
//   cq_rd{n}_*: per-thread FWFT pop ports (queue -> egress)
//   cq_idle, cq_wr_id_err, cq_rd_udf_err : status from the queue
// master = ingress/egress side, slave = the queue.
interface nv_nvdla_mcif_write_cq_if;
    import nv_nvdla_mcif_write_cq_pkg::*;

    logic                cq_wr_pvld;
    logic                cq_wr_prdy;
    logic [CQ_TID_W-1:0] cq_wr_thread_id;
    cq_rec_t             cq_wr_pd;

    logic    cq_rd0_pvld, cq_rd1_pvld, cq_rd2_pvld, cq_rd3_pvld, cq_rd4_pvld;
    logic    cq_rd0_prdy, cq_rd1_prdy, cq_rd2_prdy, cq_rd3_prdy, cq_rd4_prdy;
    cq_rec_t cq_rd0_pd, cq_rd1_pd, cq_rd2_pd, cq_rd3_pd, cq_rd4_pd;

    logic    cq_idle;
    logic    cq_wr_id_err;
    logic    cq_rd_udf_err;

    modport master (
        output cq_wr_pvld, cq_wr_thread_id, cq_wr_pd,
        input  cq_wr_prdy,
        input  cq_rd0_pvld, cq_rd1_pvld, cq_rd2_pvld, cq_rd3_pvld, cq_rd4_pvld,
        output cq_rd0_prdy, cq_rd1_prdy, cq_rd2_prdy, cq_rd3_prdy, cq_rd4_prdy,
        input  cq_rd0_pd, cq_rd1_pd, cq_rd2_pd, cq_rd3_pd, cq_rd4_pd,
        input  cq_idle, cq_wr_id_err, cq_rd_udf_err
    );

    modport slave (
        input  cq_wr_pvld, cq_wr_thread_id, cq_wr_pd,
        output cq_wr_prdy,
        output cq_rd0_pvld, cq_rd1_pvld, cq_rd2_pvld, cq_rd3_pvld, cq_rd4_pvld,
        input  cq_rd0_prdy, cq_rd1_prdy, cq_rd2_prdy, cq_rd3_prdy, cq_rd4_prdy,
        output cq_rd0_pd, cq_rd1_pd, cq_rd2_pd, cq_rd3_pd, cq_rd4_pd,
        output cq_idle, cq_wr_id_err, cq_rd_udf_err
    );

endinterface

// File: rtl/nv_nvdla_mcif_write_cq_fifo.sv
// Single-thread first-word-fall-through context FIFO.
//   push/push_pd : write request (ignored when full)
//   pop          : read request (ignored when empty)
//   pop_pd       : head record, zero when empty
//   empty/full   : occupancy flags from the wrap-bit pointers
module nv_nvdla_mcif_write_cq_fifo
    import nv_nvdla_mcif_write_cq_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic    nvdla_core_clk,
    input  logic    nvdla_core_rstn,
    input  logic    push,
    input  cq_rec_t push_pd,
    input  logic    pop,
    output cq_rec_t pop_pd,
    output logic    empty,
    output logic    full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push_fire;
    logic          pop_fire;
    cq_rec_t       store [DEPTH];

    // Extra MSB distinguishes full from empty when addresses match
    assign empty     = (rd_ptr == wr_ptr);
    assign full      = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
    assign push_fire = push & ~full;
    assign pop_fire  = pop & ~empty;

    // Pointer registers
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + PW'(1);
            if (pop_fire)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Record store, contents undefined until written
    always_ff @(posedge nvdla_core_clk) begin
        if (push_fire) store[wr_ptr[AW-1:0]] <= push_pd;
    end

    assign pop_pd = empty ? '0 : store[rd_ptr[AW-1:0]];

endmodule

// File: rtl/nv_nvdla_mcif_write_cq.sv
// MCIF write-path context queue: five per-thread in-order FIFOs of
// {len, require_ack} records pushed per AW burst and popped per B response.
//   nvdla_core_clk/nvdla_core_rstn : clock, async active-low reset
//   cq                             : push port, five pop ports, idle and
//                                    sticky error status (slave modport)
module nv_nvdla_mcif_write_cq
    import nv_nvdla_mcif_write_cq_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rstn,
    nv_nvdla_mcif_write_cq_if.slave  cq
);

    logic [CQ_THREADS-1:0] push;
    logic [CQ_THREADS-1:0] pop;
    logic [CQ_THREADS-1:0] empty;
    logic [CQ_THREADS-1:0] full;
    cq_rec_t               rd_pd [CQ_THREADS];
    logic                  wr_full_sel;
    logic                  wr_id_ok;
    logic                  push_fire;
    logic                  id_err_q;
    logic                  udf_err_q;

    assign pop = {cq.cq_rd4_prdy, cq.cq_rd3_prdy, cq.cq_rd2_prdy,
                  cq.cq_rd1_prdy, cq.cq_rd0_prdy};

    // Full flag of the addressed thread; out-of-range ids are never full
    always_comb begin
        wr_full_sel = 1'b0;
        for (int unsigned i = 0; i < CQ_THREADS; i++) begin
            if (cq.cq_wr_thread_id == CQ_TID_W'(i)) wr_full_sel = full[i];
        end
    end

    assign wr_id_ok      = cq_tid_valid(cq.cq_wr_thread_id);
    assign cq.cq_wr_prdy = ~wr_full_sel;
    assign push_fire     = cq.cq_wr_pvld & ~wr_full_sel;

    // One-hot push decode
    always_comb begin
        push = '0;
        for (int unsigned i = 0; i < CQ_THREADS; i++) begin
            push[i] = push_fire & (cq.cq_wr_thread_id == CQ_TID_W'(i));
        end
    end

    for (genvar g = 0; g < CQ_THREADS; g++) begin : g_fifo
        nv_nvdla_mcif_write_cq_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .nvdla_core_clk  (nvdla_core_clk),
            .nvdla_core_rstn (nvdla_core_rstn),
            .push            (push[g]),
            .push_pd         (cq.cq_wr_pd),
            .pop             (pop[g]),
            .pop_pd          (rd_pd[g]),
            .empty           (empty[g]),
            .full            (full[g])
        );
    end

    // Sticky error flags; underflow is judged from prdy against empty only
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            id_err_q  <= 1'b0;
            udf_err_q <= 1'b0;
        end else begin
            if (push_fire & ~wr_id_ok) id_err_q  <= 1'b1;
            if (|(pop & empty))        udf_err_q <= 1'b1;
        end
    end

    assign cq.cq_rd0_pvld   = ~empty[0];
    assign cq.cq_rd1_pvld   = ~empty[1];
    assign cq.cq_rd2_pvld   = ~empty[2];
    assign cq.cq_rd3_pvld   = ~empty[3];
    assign cq.cq_rd4_pvld   = ~empty[4];
    assign cq.cq_rd0_pd     = rd_pd[0];
    assign cq.cq_rd1_pd     = rd_pd[1];
    assign cq.cq_rd2_pd     = rd_pd[2];
    assign cq.cq_rd3_pd     = rd_pd[3];
    assign cq.cq_rd4_pd     = rd_pd[4];
    assign cq.cq_idle       = &empty;
    assign cq.cq_wr_id_err  = id_err_q;
    assign cq.cq_rd_udf_err = udf_err_q;

endmodule
